mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 192 +++++++++++++++++++
 tb/tb_mem_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: arbitrates instruction-fetch (ic) and load/store (dc) requests onto one memory port.
// Latency: accept in cycle N -> mem_req_valid from N+1; response forwarded combinationally in the mem_rsp_valid cycle.
// Backpressure: one transaction in flight; rdy only in IDLE; mem_req_valid and mem_* held until mem_req_rdy.
module mem_arb #(
  parameter int MAX_DGRANT = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            pipe_flush,
  // fetch side
  input  logic            ic_req_valid,
  output logic            ic_req_rdy,
  input  logic [AW-1:0]   ic_addr,
  output logic            ic_rsp_valid,
  output logic [DW-1:0]   ic_rsp_data,
  // load/store side
  input  logic            dc_req_valid,
  output logic            dc_req_rdy,
  input  logic            dc_rw,
  input  logic [AW-1:0]   dc_addr,
  input  logic [DW-1:0]   dc_wr_data,
  input  logic [DW/8-1:0] dc_be,
  output logic            dc_rsp_valid,
  output logic [DW-1:0]   dc_rsp_data,
  // memory side
  output logic            mem_req_valid,
  input  logic            mem_req_rdy,
  output logic            mem_rw,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wr_data,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,
  output logic            busy_out
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_DGRANT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // latched request and its owner (1 = dc)
  logic          owner_dc;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;

  logic [CW-1:0] dgrant_cnt;
  logic          drop;
  // low through reset and the first edge after release, so no accept can
  // coincide with the release edge
  logic          armed;

  logic          cnt_full;
  logic          dc_sel;
  logic          ic_sel;
  logic          ic_acc;
  logic          dc_acc;
  logic          acc;
  logic          flush_hit;
  logic          rsp_take;

  // dc normally wins; a starved fetch takes over once dc has had MAX_DGRANT grants in a row
  assign cnt_full  = (dgrant_cnt == CW'(MAX_DGRANT));
  assign dc_sel    = dc_req_valid & ~(ic_req_valid & cnt_full);
  assign ic_sel    = ic_req_valid & ~dc_sel;

  assign ic_acc    = ic_req_valid & ic_req_rdy;
  assign dc_acc    = dc_req_valid & dc_req_rdy;
  assign acc       = ic_acc | dc_acc;

  // a flush only matters for a fetch that is already in flight
  assign flush_hit = pipe_flush & ~owner_dc & ((state == REQ) | (state == WAIT));
  assign rsp_take  = (state == WAIT) & mem_rsp_valid;

  // memory request fields come straight from the latch so they cannot move while waiting for rdy
  assign mem_rw      = req_rw;
  assign mem_addr    = req_addr;
  assign mem_wr_data = req_wdata;
  assign mem_be      = req_be;

  // state register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  // next-state: one transaction at a time, IDLE -> REQ -> WAIT -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc)           state_nxt = REQ;
      REQ:     if (mem_req_rdy)   state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // outputs: handshakes per state, response steered to the owner and zeroed otherwise
  always_comb begin
    ic_req_rdy    = 1'b0;
    dc_req_rdy    = 1'b0;
    mem_req_valid = 1'b0;
    ic_rsp_valid  = 1'b0;
    dc_rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        ic_req_rdy = armed & ic_sel;
        dc_req_rdy = armed & dc_sel;
      end
      REQ: mem_req_valid = 1'b1;
      WAIT: begin
        if (mem_rsp_valid) begin
          if (owner_dc) dc_rsp_valid = 1'b1;
          else          ic_rsp_valid = ~drop & ~pipe_flush;
        end
      end
      default: ;
    endcase
    busy_out    = (state != IDLE);
    ic_rsp_data = ic_rsp_valid ? mem_rsp_data : '0;
    dc_rsp_data = dc_rsp_valid ? mem_rsp_data : '0;
  end

  // latch the accepted request; fetches are full-word reads
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      owner_dc  <= 1'b0;
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
    end else if (dc_acc) begin
      owner_dc  <= 1'b1;
      req_rw    <= dc_rw;
      req_addr  <= dc_addr;
      req_wdata <= dc_wr_data;
      req_be    <= dc_be;
    end else if (ic_acc) begin
      owner_dc  <= 1'b0;
      req_rw    <= 1'b0;
      req_addr  <= ic_addr;
      req_wdata <= '0;
      req_be    <= '1;
    end
  end

  // count dc grants that jumped a waiting fetch; any fetch grant or idle fetch side resets it
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      dgrant_cnt <= '0;
    end else if (state == IDLE) begin
      if (dc_acc && ic_req_valid) begin
        if (!cnt_full) dgrant_cnt <= dgrant_cnt + 1'b1;
      end else if (ic_acc || !ic_req_valid) begin
        dgrant_cnt <= '0;
      end
    end
  end

  // remember a flushed fetch so its response is consumed but not forwarded
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)    drop <= 1'b0;
    else if (rsp_take)  drop <= 1'b0;
    else if (flush_hit) drop <= 1'b1;
  end

  // open the request side one edge after reset release
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) armed <= 1'b0;
    else             armed <= 1'b1;
  end

  // a presented memory request must not be withdrawn or altered before it is taken
  a_req_hold: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    (mem_req_valid && !mem_req_rdy) |=> (mem_req_valid && $stable(mem_addr) && $stable(mem_wr_data)));

  // at most one requester is offered the port
  a_rdy_onehot: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    !(ic_req_rdy && dc_req_rdy));

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with a response scoreboard and memory-side driver tasks.
// Latency: expectations pushed at issue time, popped by a monitor on every forwarded response.
// Backpressure: memory rdy/rsp timing chosen per vector; every wait is cycle-bounded.
`timescale 1ns/1ps
module tb_mem_arb;

  logic        clk_in       = 1'b0;
  logic        reset_n_in   = 1'b0;
  logic        pipe_flush   = 1'b0;
  logic        ic_req_valid = 1'b0;
  logic        ic_req_rdy;
  logic [31:0] ic_addr      = '0;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_data;
  logic        dc_req_valid = 1'b0;
  logic        dc_req_rdy;
  logic        dc_rw        = 1'b0;
  logic [31:0] dc_addr      = '0;
  logic [31:0] dc_wr_data   = '0;
  logic [3:0]  dc_be        = '0;
  logic        dc_rsp_valid;
  logic [31:0] dc_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_rdy  = 1'b0;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = '0;
  logic        busy_out;

  int total = 0;
  int bad   = 0;

  // expected response: {is_dc, data}
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic [32:0] mon_got;

  mem_arb #(.MAX_DGRANT(4), .AW(32), .DW(32)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .pipe_flush    (pipe_flush),
    .ic_req_valid  (ic_req_valid),
    .ic_req_rdy    (ic_req_rdy),
    .ic_addr       (ic_addr),
    .ic_rsp_valid  (ic_rsp_valid),
    .ic_rsp_data   (ic_rsp_data),
    .dc_req_valid  (dc_req_valid),
    .dc_req_rdy    (dc_req_rdy),
    .dc_rw         (dc_rw),
    .dc_addr       (dc_addr),
    .dc_wr_data    (dc_wr_data),
    .dc_be         (dc_be),
    .dc_rsp_valid  (dc_rsp_valid),
    .dc_rsp_data   (dc_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_rdy   (mem_req_rdy),
    .mem_rw        (mem_rw),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic is_dc, input logic [31:0] data);
    exp_q.push_back({is_dc, data});
  endtask

  // hold valid until a rdy is seen, then drop it after the accepting edge
  task automatic issue_ic(input logic [31:0] addr);
    int n = 0;
    ic_addr      = addr;
    ic_req_valid = 1'b1;
    while (n < 40) begin
      @(negedge clk_in);
      if (ic_req_rdy) break;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL ic_accept_timeout: got no rdy want rdy addr=%0h", addr);
    end
    @(posedge clk_in); #1;
    ic_req_valid = 1'b0;
  endtask

  task automatic issue_dc(input logic rw, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    dc_rw        = rw;
    dc_addr      = addr;
    dc_wr_data   = wd;
    dc_be        = be;
    dc_req_valid = 1'b1;
    while (n < 40) begin
      @(negedge clk_in);
      if (dc_req_rdy) break;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL dc_accept_timeout: got no rdy want rdy addr=%0h", addr);
    end
    @(posedge clk_in); #1;
    dc_req_valid = 1'b0;
    dc_rw        = 1'b0;
    dc_wr_data   = '0;
  endtask

  // wait for a memory request, check its fields for every cycle it is held, then take it
  task automatic mem_handshake(input string nm, input int rdy_wait, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    while (!mem_req_valid && n < 40) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({nm, "_req"}, {mem_req_valid, mem_rw, mem_addr, mem_wr_data, mem_be}, {1'b1, rw, addr, wd, be});
    for (int i = 0; i < rdy_wait; i++) begin
      @(posedge clk_in); #1;
      chk({nm, "_hold"}, {mem_req_valid, mem_rw, mem_addr, mem_wr_data, mem_be}, {1'b1, rw, addr, wd, be});
    end
    mem_req_rdy = 1'b1;
    @(posedge clk_in); #1;
    mem_req_rdy = 1'b0;
  endtask

  // one-cycle memory response, optionally with pipe_flush in the same cycle
  task automatic mem_respond(input int rsp_wait, input logic [31:0] data, input logic flush);
    repeat (rsp_wait) begin
      @(posedge clk_in); #1;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    pipe_flush    = flush;
    @(posedge clk_in); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    pipe_flush    = 1'b0;
  endtask

  // monitor: every forwarded response must match the head of the scoreboard
  always @(negedge clk_in) begin
    total++;
    if ((!ic_rsp_valid && ic_rsp_data != '0) || (!dc_rsp_valid && dc_rsp_data != '0)) begin
      bad++;
      $display("FAIL rsp_data_idle: got ic=%0h dc=%0h want 0", ic_rsp_data, dc_rsp_data);
    end
    if (ic_rsp_valid || dc_rsp_valid) begin
      total++;
      if (ic_rsp_valid && dc_rsp_valid) begin
        bad++;
        $display("FAIL rsp_both: got ic and dc valid want one");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got dc=%0b data=%0h want none", dc_rsp_valid,
                 dc_rsp_valid ? dc_rsp_data : ic_rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {dc_rsp_valid, dc_rsp_valid ? dc_rsp_data : ic_rsp_data};
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL rsp_match: got %0h want %0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, sampled after an edge while reset is still low
    @(posedge clk_in); #1;
    chk("rst_ctrl", {ic_req_rdy, dc_req_rdy, ic_rsp_valid, dc_rsp_valid, mem_req_valid, mem_rw, busy_out}, 7'b0);
    chk("rst_mem_fields", {mem_addr, mem_wr_data, mem_be}, 68'b0);
    repeat (2) @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // single fetch, response two cycles after the memory handshake
    exp_push(1'b0, 32'hDEADBEEF);
    issue_ic(32'h100);
    chk("t1_req_latency", {mem_req_valid, busy_out}, 2'b11);
    mem_handshake("t1", 0, 1'b0, 32'h100, 32'h0, 4'hF);
    mem_respond(1, 32'hDEADBEEF, 1'b0);
    chk("t1_busy_after", busy_out, 1'b0);

    // both requesters always valid: dc x4 then ic, twice
    ic_addr      = 32'h1000;
    dc_addr      = 32'h2000;
    dc_rw        = 1'b0;
    dc_wr_data   = '0;
    dc_be        = 4'hF;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_push((i % 5) != 4, 32'h5000_0000 + i);
      mem_handshake("t2_grant", 0, 1'b0, ((i % 5) == 4) ? 32'h1000 : 32'h2000, 32'h0, 4'hF);
      if (i == 9) begin
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
      end
      mem_respond(0, 32'h5000_0000 + i, 1'b0);
    end

    // dc write held under three cycles of memory backpressure
    exp_push(1'b1, 32'h0000_0001);
    issue_dc(1'b1, 32'h20, 32'h12345678, 4'hF);
    mem_handshake("t3_wr", 3, 1'b1, 32'h20, 32'h12345678, 4'hF);
    mem_respond(0, 32'h0000_0001, 1'b0);

    // flush while a fetch waits for its response: consumed silently
    issue_ic(32'h200);
    mem_handshake("t4_fl", 0, 1'b0, 32'h200, 32'h0, 4'hF);
    pipe_flush = 1'b1;
    @(posedge clk_in); #1;
    pipe_flush = 1'b0;
    mem_respond(1, 32'h11111111, 1'b0);
    chk("t4_idle", busy_out, 1'b0);
    exp_push(1'b0, 32'h22222222);
    issue_ic(32'h300);
    mem_handshake("t4_next", 0, 1'b0, 32'h300, 32'h0, 4'hF);
    mem_respond(0, 32'h22222222, 1'b0);

    // flush in the same cycle as the fetch response
    issue_ic(32'h340);
    mem_handshake("t5", 0, 1'b0, 32'h340, 32'h0, 4'hF);
    mem_respond(0, 32'h33333333, 1'b1);
    chk("t5_idle", busy_out, 1'b0);

    // flush while the fetch is still in REQ: request must stay up
    issue_ic(32'h380);
    pipe_flush = 1'b1;
    @(posedge clk_in); #1;
    pipe_flush = 1'b0;
    chk("t6_req_kept", mem_req_valid, 1'b1);
    mem_handshake("t6", 1, 1'b0, 32'h380, 32'h0, 4'hF);
    mem_respond(0, 32'h44444444, 1'b0);

    // flush alongside a dc load response: dc is never dropped
    exp_push(1'b1, 32'hA5A5A5A5);
    issue_dc(1'b0, 32'h60, 32'h0, 4'hF);
    mem_handshake("t7", 0, 1'b0, 32'h60, 32'h0, 4'hF);
    mem_respond(0, 32'hA5A5A5A5, 1'b1);

    // flush held in IDLE while a fetch is accepted: no effect
    exp_push(1'b0, 32'h55555555);
    pipe_flush = 1'b1;
    issue_ic(32'h500);
    pipe_flush = 1'b0;
    mem_handshake("t8", 0, 1'b0, 32'h500, 32'h0, 4'hF);
    mem_respond(0, 32'h55555555, 1'b0);

    // reset in the middle of a request, with both requesters valid
    issue_ic(32'h600);
    chk("t9_in_req", mem_req_valid, 1'b1);
    ic_addr      = 32'h700;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    reset_n_in   = 1'b0;
    #1;
    chk("t9_rst_ctrl", {mem_req_valid, busy_out, ic_req_rdy, dc_req_rdy}, 4'b0);
    chk("t9_rst_addr", {mem_addr, mem_be}, 36'b0);
    @(posedge clk_in); #1;
    chk("t9_rst_hold", {mem_req_valid, busy_out, ic_req_rdy, dc_req_rdy}, 4'b0);
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    reset_n_in   = 1'b1;
    @(posedge clk_in); #1;
    // stray response outside WAIT is ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0BAD0;
    @(posedge clk_in); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    chk("t9_after", {mem_req_valid, busy_out}, 2'b00);
    exp_push(1'b1, 32'h66666666);
    issue_dc(1'b0, 32'h80, 32'h0, 4'h3);
    mem_handshake("t9_next", 0, 1'b0, 32'h80, 32'h0, 4'h3);
    mem_respond(0, 32'h66666666, 1'b0);

    repeat (3) @(posedge clk_in);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
